// File: rtl/vga_fb_reader_if.sv
// Framebuffer read port and bank-swap handshake shared by the VGA reader,
// the framebuffer RAM and the frame writer.
interface vga_fb_reader_if;
  logic [15:0] fb_addr;
  logic        fb_en;
  logic [7:0]  fb_rdata;
  logic        swap_req;
  logic        swap_ack;
  logic        back_bank;

  modport master (
    output fb_addr,
    output fb_en,
    input  fb_rdata,
    input  swap_req,
    output swap_ack,
    output back_bank
  );

  modport slave (
    input  fb_addr,
    input  fb_en,
    output fb_rdata,
    output swap_req,
    input  swap_ack,
    input  back_bank
  );
endinterface

// File: rtl/vga_fb_reader.sv
// Double-buffered framebuffer reader: runs 3 pixels ahead of the VGA driver,
// fetches RGB332 from the displayed bank and expands it to 24-bit colour.
module vga_fb_reader #(
  parameter int FB_W     = 160,
  parameter int FB_H     = 120,
  parameter int SCALE_SH = 2,
  parameter int SCREEN_X = 640,
  parameter int SCREEN_Y = 480,
  parameter int H_LAST   = 840,
  parameter int V_LAST   = 500
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [10:0]     posX,
  input  logic [10:0]     posY,
  input  logic            pattern_en,
  output logic [23:0]     pixelIn,
  vga_fb_reader_if.master fb
);

  localparam logic [11:0] H_WRAP   = 12'(H_LAST + 1);
  localparam logic [10:0] V_END    = 11'(V_LAST);
  localparam logic [10:0] VIS_X    = 11'(SCREEN_X);
  localparam logic [10:0] VIS_Y    = 11'(SCREEN_Y);
  localparam logic [15:0] BANK_OFF = 16'(FB_W * FB_H);

  logic        front;
  logic [11:0] tx_ahead;
  logic [10:0] tx;
  logic [10:0] ty;
  logic        target_vis;
  logic        fetch;
  logic [15:0] row;
  logic [15:0] col;
  logic [15:0] addr_next;
  logic        swap_event;

  logic        s0_vis;
  logic        s0_pat;
  logic [2:0]  s0_bar;
  logic        s1_vis;
  logic        s1_pat;
  logic [2:0]  s1_bar;

  function automatic logic [23:0] bar_colour(input logic [2:0] sel);
    case (sel)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  // Replicate the high bits so full-scale RGB332 maps to full-scale 8-bit.
  function automatic logic [23:0] expand332(input logic [7:0] d);
    expand332 = {d[7:5], d[7:5], d[7:6],
                 d[4:2], d[4:2], d[4:3],
                 {4{d[1:0]}}};
  endfunction

  // Target pixel is 3 columns ahead; wrapping past H_LAST moves to the next row.
  always_comb begin
    tx_ahead = {1'b0, posX} + 12'd3;
    tx       = tx_ahead[10:0];
    ty       = posY;
    if (tx_ahead >= H_WRAP) begin
      tx = 11'(tx_ahead - H_WRAP);
      ty = (posY == V_END) ? 11'd0 : posY + 11'd1;
    end
    target_vis = (tx < VIS_X) && (ty < VIS_Y);
    fetch      = target_vis && !pattern_en;
    row        = 16'(ty >> SCALE_SH);
    col        = 16'(tx >> SCALE_SH);
    addr_next  = (front ? BANK_OFF : 16'd0) + (row << 7) + (row << 5) + col;
    swap_event = (posX == 11'd0) && (posY == VIS_Y);
  end

  assign fb.back_bank = ~front;

  always_ff @(posedge clk) begin
    if (rst) begin
      front       <= 1'b0;
      fb.fb_en    <= 1'b0;
      fb.fb_addr  <= 16'd0;
      fb.swap_ack <= 1'b0;
      s0_vis      <= 1'b0;
      s0_pat      <= 1'b0;
      s0_bar      <= 3'd0;
      s1_vis      <= 1'b0;
      s1_pat      <= 1'b0;
      s1_bar      <= 3'd0;
      pixelIn     <= 24'h000000;
    end else begin
      fb.fb_en <= fetch;
      if (fetch) begin
        fb.fb_addr <= addr_next;
      end
      s0_vis <= target_vis;
      s0_pat <= pattern_en;
      s0_bar <= tx[9:7];
      s1_vis <= s0_vis;
      s1_pat <= s0_pat;
      s1_bar <= s0_bar;

      // fb_rdata lines up with the S1 side-band flags here.
      if (!s1_vis) begin
        pixelIn <= 24'h000000;
      end else if (s1_pat) begin
        pixelIn <= bar_colour(s1_bar);
      end else begin
        pixelIn <= expand332(fb.fb_rdata);
      end

      fb.swap_ack <= swap_event && fb.swap_req;
      if (swap_event && fb.swap_req) begin
        front <= ~front;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_reader.sv
// Table-driven bench for vga_fb_reader: per-cycle vectors check the S0 fetch
// and swap handshake, a scoreboard queue checks pixelIn three clocks later.
module tb_vga_fb_reader;

  typedef struct {
    logic        rst;
    logic [10:0] x;
    logic [10:0] y;
    logic        pat;
    logic        req;
    logic        en;
    logic [15:0] addr;
    logic [23:0] px;
    logic        ack;
    logic        back;
  } vec_t;

  typedef struct {
    int          due;
    logic [23:0] px;
    int          idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] posX = 11'd0;
  logic [10:0] posY = 11'd0;
  logic        pattern_en = 1'b0;
  logic [23:0] pixelIn;

  vga_fb_reader_if bus();

  vga_fb_reader dut (
    .clk        (clk),
    .rst        (rst),
    .posX       (posX),
    .posY       (posY),
    .pattern_en (pattern_en),
    .pixelIn    (pixelIn),
    .fb         (bus)
  );

  always #20 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  vec_t vecs[$];
  exp_t sb[$];

  // Framebuffer contents are a fixed function of address; address 0 holds pure red.
  function automatic logic [7:0] ramVal(input logic [15:0] a);
    if (a == 16'd0) return 8'hE0;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [23:0] expandPx(input logic [7:0] d);
    return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], d[1:0], d[1:0], d[1:0], d[1:0]};
  endfunction

  function automatic logic [23:0] rx(input int a);
    return expandPx(ramVal(16'(a)));
  endfunction

  always @(posedge clk) begin
    if (bus.fb_en) bus.fb_rdata <= ramVal(bus.fb_addr);
  end

  function automatic vec_t mk(input logic r, input int x, input int y, input logic p,
                              input logic q, input logic en, input int addr,
                              input logic [23:0] px, input logic ack, input logic back);
    vec_t v;
    v.rst  = r;
    v.x    = 11'(x);
    v.y    = 11'(y);
    v.pat  = p;
    v.req  = q;
    v.en   = en;
    v.addr = 16'(addr);
    v.px   = px;
    v.ack  = ack;
    v.back = back;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [23:0] got, input logic [23:0] want);
    checks++;
    if (got === want) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
  endtask

  task automatic popPixel();
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      checkOutput($sformatf("vec%0d pixelIn", e.idx), pixelIn, e.px);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    rst          = v.rst;
    posX         = v.x;
    posY         = v.y;
    pattern_en   = v.pat;
    bus.swap_req = v.req;
    if (!v.rst) sb.push_back('{cyc + 3, v.px, idx});
    @(posedge clk);
    cyc++;
    #1;
    if (v.rst) begin
      // In-flight pixels are discarded; the next two outputs come from a flushed pipeline.
      sb.delete();
      sb.push_back('{cyc + 1, 24'h0, idx});
      sb.push_back('{cyc + 2, 24'h0, idx});
      checkOutput($sformatf("vec%0d pixelIn during reset", idx), pixelIn, 24'h0);
    end
    checkOutput($sformatf("vec%0d fb_en", idx), 24'(bus.fb_en), 24'(v.en));
    checkOutput($sformatf("vec%0d fb_addr", idx), 24'(bus.fb_addr), 24'(v.addr));
    checkOutput($sformatf("vec%0d swap_ack", idx), 24'(bus.swap_ack), 24'(v.ack));
    checkOutput($sformatf("vec%0d back_bank", idx), 24'(bus.back_bank), 24'(v.back));
    popPixel();
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      cyc++;
      #1;
      guard++;
      popPixel();
    end
    checkOutput("scoreboard drained", 24'(sb.size()), 24'h0);
  endtask

  initial begin
    bus.swap_req = 1'b0;
    //                rst  x    y   pat req  en  addr   px              ack back
    vecs.push_back(mk(1,   0,   0,  0,  0,   0,  0,     24'h0,          0,  1));
    vecs.push_back(mk(1,   0,   0,  0,  0,   0,  0,     24'h0,          0,  1));
    vecs.push_back(mk(0,   0,   0,  0,  0,   1,  0,     24'hFF0000,     0,  1));
    vecs.push_back(mk(0,   633, 7,  0,  0,   1,  319,   rx(319),        0,  1));
    vecs.push_back(mk(0,   637, 7,  0,  0,   0,  319,   24'h0,          0,  1));
    vecs.push_back(mk(0,   838, 479,0,  0,   0,  319,   24'h0,          0,  1));
    vecs.push_back(mk(0,   838, 500,0,  0,   1,  0,     24'hFF0000,     0,  1));
    vecs.push_back(mk(0,   253, 10, 1,  0,   0,  0,     24'h00FFFF,     0,  1));
    vecs.push_back(mk(0,   100, 200,1,  0,   0,  0,     24'hFFFFFF,     0,  1));
    vecs.push_back(mk(0,   517, 50, 1,  0,   0,  0,     24'hFF00FF,     0,  1));
    vecs.push_back(mk(0,   837, 20, 0,  0,   0,  0,     24'h0,          0,  1));
    vecs.push_back(mk(0,   839, 20, 0,  0,   1,  800,   rx(800),        0,  1));
    vecs.push_back(mk(0,   636, 479,0,  0,   1,  19199, rx(19199),      0,  1));
    vecs.push_back(mk(0,   4,   480,0,  0,   0,  19199, 24'h0,          0,  1));
    vecs.push_back(mk(0,   0,   100,0,  1,   1,  4000,  rx(4000),       0,  1));
    vecs.push_back(mk(0,   0,   479,0,  1,   1,  19040, rx(19040),      0,  1));
    vecs.push_back(mk(0,   0,   480,0,  1,   0,  19040, 24'h0,          1,  0));
    vecs.push_back(mk(0,   1,   480,0,  0,   0,  19040, 24'h0,          0,  0));
    vecs.push_back(mk(0,   838, 500,0,  0,   1,  19200, rx(19200),      0,  0));
    vecs.push_back(mk(0,   0,   480,0,  0,   0,  19200, 24'h0,          0,  0));
    vecs.push_back(mk(0,   0,   481,0,  1,   0,  19200, 24'h0,          0,  0));
    vecs.push_back(mk(0,   0,   480,0,  1,   0,  19200, 24'h0,          1,  1));
    vecs.push_back(mk(0,   1,   0,  0,  1,   1,  1,     rx(1),          0,  1));
    vecs.push_back(mk(0,   0,   480,0,  1,   0,  1,     24'h0,          1,  0));
    vecs.push_back(mk(0,   5,   9,  0,  0,   1,  19522, rx(19522),      0,  0));
    vecs.push_back(mk(1,   0,   480,0,  1,   0,  0,     24'h0,          0,  1));
    vecs.push_back(mk(0,   0,   0,  0,  0,   1,  0,     24'hFF0000,     0,  1));
    vecs.push_back(mk(0,   400, 300,0,  0,   1,  12100, rx(12100),      0,  1));
    vecs.push_back(mk(0,   800, 300,0,  0,   0,  12100, 24'h0,          0,  1));
    vecs.push_back(mk(0,   200, 0,  0,  0,   1,  50,    rx(50),         0,  1));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
